fp8_operand_sequencer: RTL
==========================

// Module: fp8_operand_sequencer
// PURPOSE
//  Input-side sequencer for the 8-bit FP adder top. Loads operands A and B serially
//  from the 8-bit dedicated input bus via a pin strobe, drives the adder core, and
//  captures its sum into a stable result register for uo_out. Status goes to uio_out.
// PARAMETERS
//  ADD_LAT      1  cycles from op_a/op_b stable to add_sum valid (0..7; 0 = combinational)
//  SYNC_STAGES  2  synchroniser flops on the strobe pin (2..3)
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  rst_n       in   1  asynchronous active-low reset
//  ena         in   1  design-select enable; low freezes FSM, strobes dropped
//  data_in     in   8  operand byte (ui_in)
//  strobe_pin  in   1  asynchronous load strobe (uio_in[0])
//  acc_mode    in   1  accumulate request (uio_in[1]); used only with ACCUMULATE_EN
//  op_a        out  8  operand A to adder core
//  op_b        out  8  operand B to adder core
//  add_sum     in   8  sum from adder core
//  result_out  out  8  captured sum (uo_out)
//  busy        out  1  high in EXEC
//  valid       out  1  high while result_out holds a fresh sum
//  need_b      out  1  high in WAIT_B
// BEHAVIOUR
//  - Reset (async assert, sync release): state=WAIT_A; op_a, op_b, result_out=8'h00;
//    busy, valid, need_b=0; sync chain and edge-detect flop=0; lat_cnt=0.
//  - strobe_pin passes SYNC_STAGES flops, then rising-edge detect -> 1-cycle stb pulse.
//    Strobe-to-stb latency = SYNC_STAGES+1 cycles. data_in is sampled in the stb cycle.
//    Source holds data_in stable from strobe rise until stb.
//  - FSM (transitions only when ena=1; with ena=0, all regs hold and stb is discarded):
//    WAIT_A: stb -> op_a<=data_in, valid<=0, go WAIT_B.
//    WAIT_B: stb -> op_b<=data_in, lat_cnt<=ADD_LAT, go EXEC.
//    EXEC:   lat_cnt!=0 -> decrement; lat_cnt==0 -> result_out<=add_sum, valid<=1, go HOLD.
//            stb in EXEC is ignored, not queued.
//    HOLD:   result_out/valid held; stb -> op_a<=data_in, valid<=0, go WAIT_B.
//  - Latency: B-latching edge to valid=1 is ADD_LAT+2 cycles.
//  - op_a/op_b change only at stb edges, so they stay stable throughout EXEC.
//  - busy=(state==EXEC), need_b=(state==WAIT_B); both registered from state.
//  - No arithmetic here; add_sum is passed through unmodified (no rounding or flags).
//  - rst_n low at any point, mid-EXEC included, aborts at once; the captured sum is lost.
//  - Strobe held high counts once; a new stb needs a low period of at least 1 synced cycle.
// CONFIGURATION
//  ACCUMULATE_EN defined: in HOLD with acc_mode=1, stb -> op_a<=result_out,
//    op_b<=data_in, lat_cnt<=ADD_LAT, go EXEC. This is one-strobe chained addition.
//    acc_mode is sampled in the stb cycle. acc_mode=0 gives base behaviour.
//  ACCUMULATE_EN undefined: acc_mode ignored (tie-off, no logic); HOLD behaves as above.
// TESTING (bench stub adder: add_sum = op_a + op_b mod 256, delayed ADD_LAT cycles)
//  1 Reset then idle 20 cycles -> result_out=00, valid=0, busy=0, need_b=0.
//  2 Strobe with data 0x38, then strobe with 0x41 -> need_b=1 between strobes;
//    op_a=38, op_b=41; busy for ADD_LAT+1 cycles; result_out=79, valid=1 ADD_LAT+2 after stb.
//  3 Extra strobe while busy=1 -> ignored; result 79 still captured; FSM goes HOLD, not WAIT_B.
//  4 Deassert rst_n mid-EXEC -> all outputs 00/0 immediately; after release, a fresh
//    A/B load 0x10/0x05 yields 15.
//  5 ena=0 during WAIT_B with a strobe of 0x22 -> ignored, op_b unchanged;
//    ena=1 and strobe 0x22 -> sum captured.
//  6 ACCUMULATE_EN, result 79 in HOLD, acc_mode=1, strobe 0x07 -> op_a=79, op_b=07,
//    result_out=80; without the macro the same stimulus loads op_a=07, need_b=1.

Source files
------------

// File: rtl/fp8_operand_sequencer.sv
// Purpose: loads FP8 operands A/B serially through a synchronised strobe, drives the adder core, captures its sum.
// Latency: stb -> op latched next edge; B-latching stb to valid=1 is ADD_LAT+2 cycles.
// Backpressure: none; stb in EXEC is dropped, ena=0 freezes the FSM and drops stb. Optional: ACCUMULATE_EN.
module fp8_operand_sequencer #(
    parameter int ADD_LAT     = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] data_in,
    input  logic       strobe_pin,
    input  logic       acc_mode,
    output logic [7:0] op_a,
    output logic [7:0] op_b,
    input  logic [7:0] add_sum,
    output logic [7:0] result_out,
    output logic       busy,
    output logic       valid,
    output logic       need_b
);

    typedef enum logic [1:0] {WAIT_A, WAIT_B, EXEC, HOLD} state_t;

    localparam logic [2:0] LAT_INIT = 3'(ADD_LAT);

    state_t                 state, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   edge_q;
    logic                   stb;
    logic                   acc_go;
    logic [2:0]             lat_cnt, lat_cnt_d;
    logic [7:0]             op_a_d, op_b_d, result_d;
    logic                   valid_d, busy_d, need_b_d;

`ifdef ACCUMULATE_EN
    assign acc_go = acc_mode;
`else
    // Accumulate path compiled out; acc_mode is a tie-off.
    logic unused_acc_mode;
    assign unused_acc_mode = acc_mode;
    assign acc_go          = 1'b0;
`endif

    // Strobe synchroniser and edge-detect flop; free-running so ena=0 drops pulses instead of deferring them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_pin};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign stb = sync_q[SYNC_STAGES-1] & ~edge_q;

    // State and registered outputs; everything holds while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= WAIT_A;
            lat_cnt    <= 3'd0;
            op_a       <= 8'h00;
            op_b       <= 8'h00;
            result_out <= 8'h00;
            valid      <= 1'b0;
            busy       <= 1'b0;
            need_b     <= 1'b0;
        end else if (ena) begin
            state      <= state_d;
            lat_cnt    <= lat_cnt_d;
            op_a       <= op_a_d;
            op_b       <= op_b_d;
            result_out <= result_d;
            valid      <= valid_d;
            busy       <= busy_d;
            need_b     <= need_b_d;
        end
    end

    // Next-state: strobes advance the load sequence, the latency counter ends EXEC.
    always_comb begin
        state_d = state;
        case (state)
            WAIT_A: if (stb) state_d = WAIT_B;
            WAIT_B: if (stb) state_d = EXEC;
            EXEC:   if (lat_cnt == 3'd0) state_d = HOLD;
            HOLD:   if (stb) state_d = acc_go ? EXEC : WAIT_B;
            default: state_d = WAIT_A;
        endcase
    end

    // Next values of the operand, result and status registers.
    always_comb begin
        op_a_d    = op_a;
        op_b_d    = op_b;
        result_d  = result_out;
        valid_d   = valid;
        lat_cnt_d = lat_cnt;
        case (state)
            WAIT_A: begin
                if (stb) begin
                    op_a_d  = data_in;
                    valid_d = 1'b0;
                end
            end
            WAIT_B: begin
                if (stb) begin
                    op_b_d    = data_in;
                    lat_cnt_d = LAT_INIT;
                end
            end
            EXEC: begin
                if (lat_cnt != 3'd0) begin
                    lat_cnt_d = lat_cnt - 3'd1;
                end else begin
                    result_d = add_sum;
                    valid_d  = 1'b1;
                end
            end
            HOLD: begin
                if (stb) begin
                    valid_d = 1'b0;
                    if (acc_go) begin
                        // Chained add: previous sum becomes A, the strobed byte becomes B.
                        op_a_d    = result_out;
                        op_b_d    = data_in;
                        lat_cnt_d = LAT_INIT;
                    end else begin
                        op_a_d = data_in;
                    end
                end
            end
            default: ;
        endcase
        busy_d   = (state_d == EXEC);
        need_b_d = (state_d == WAIT_B);
    end

endmodule
